// File: rtl/dds_multi_gen.sv
// Multi-channel DDS generator: shared sample-rate divider, per-channel
// phase accumulators with sweep, shadow config committed on a sample tick.
module dds_multi_gen #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 12,
  parameter int DIV_W   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_wr,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [2:0]                                cfg_addr,
  input  logic [PHASE_W-1:0]                        cfg_data,
  output logic                                      cfg_ready,
  output logic [N_CH*DATA_W-1:0]                    wave_out,
  output logic                                      wave_valid
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_sh;
  logic             pending;
  logic             sync_sh;
  logic             tick;
  logic             apply;
  logic             accept;
  logic             ch_ok;

  logic [PHASE_W-1:0] ftw_sh  [N_CH];
  logic [PHASE_W-1:0] off_sh  [N_CH];
  logic [PHASE_W-1:0] step_sh [N_CH];
  logic [PHASE_W-1:0] lim_sh  [N_CH];
  logic [DATA_W-1:0]  amp_sh  [N_CH];
  logic [3:0]         mode_sh [N_CH];

  logic [PHASE_W-1:0] ftw_st  [N_CH];
  logic [PHASE_W-1:0] off_a   [N_CH];
  logic [PHASE_W-1:0] step_a  [N_CH];
  logic [PHASE_W-1:0] lim_a   [N_CH];
  logic [DATA_W-1:0]  amp_a   [N_CH];
  logic [3:0]         mode_a  [N_CH];

  logic [PHASE_W-1:0]  ftw_cur [N_CH];
  logic [PHASE_W-1:0]  acc     [N_CH];
  logic [PHASE_W-1:0]  acc_n   [N_CH];
  logic [PHASE_W-1:0]  cur_n   [N_CH];
  logic [PHASE_W:0]    sum     [N_CH];
  logic [PHASE_W-1:0]  phase   [N_CH];
  logic [DATA_W-1:0]   raw_n   [N_CH];
  logic [DATA_W-1:0]   raw_q   [N_CH];
  logic [2*DATA_W-1:0] prod    [N_CH];
  logic                raw_v;

  assign tick      = (cnt == div_act);
  assign apply     = tick & pending;
  assign cfg_ready = ~pending;
  assign accept    = cfg_wr & ~pending;
  assign ch_ok     = int'(cfg_ch) < N_CH;

  function automatic logic [DATA_W-1:0] shape(
    input logic [PHASE_W-1:0] p,
    input logic [3:0]         md
  );
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] r;
    u = p[PHASE_W-1 -: DATA_W];
    d = {u[DATA_W-2:0], 1'b0};
    r = '0;
    if (md[2]) begin
      unique case (md[1:0])
        2'd0: r = {DATA_W{u[DATA_W-1]}};
        2'd1: r = u;
        2'd2: r = u[DATA_W-1] ? ~d : d;
        default: r = '1;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_sh <= '0;
      for (int k = 0; k < N_CH; k++) begin
        ftw_sh[k]  <= '0;
        off_sh[k]  <= '0;
        step_sh[k] <= '0;
        lim_sh[k]  <= '0;
        amp_sh[k]  <= '1;
        mode_sh[k] <= '0;
      end
    end else if (accept) begin
      unique case (cfg_addr)
        3'd0: if (ch_ok) ftw_sh[cfg_ch] <= cfg_data;
        3'd1: if (ch_ok) off_sh[cfg_ch] <= cfg_data;
        3'd2: if (ch_ok) amp_sh[cfg_ch] <= cfg_data[DATA_W-1:0];
        3'd3: if (ch_ok) mode_sh[cfg_ch] <= cfg_data[3:0];
        3'd4: if (ch_ok) step_sh[cfg_ch] <= cfg_data;
        3'd5: if (ch_ok) lim_sh[cfg_ch] <= cfg_data;
        3'd6: div_sh <= cfg_data[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // accept only happens with pending low, so set and clear never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= '0;
      pending <= 1'b0;
      sync_sh <= 1'b0;
    end else begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + DIV_W'(1);
      if (apply) begin
        div_act <= div_sh;
        pending <= 1'b0;
      end
      if (accept && cfg_addr == 3'd7 && cfg_data[0]) begin
        pending <= 1'b1;
        sync_sh <= cfg_data[1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      sum[k]   = {1'b0, ftw_cur[k]} + {1'b0, step_a[k]};
      acc_n[k] = acc[k];
      cur_n[k] = ftw_cur[k];
      if (tick) begin
        acc_n[k] = mode_a[k][2] ? acc[k] + ftw_cur[k] : '0;
        if (mode_a[k][3]) begin
          if (sum[k] > {1'b0, lim_a[k]}) cur_n[k] = ftw_st[k];
          else                           cur_n[k] = sum[k][PHASE_W-1:0];
        end
      end
      if (apply) begin
        cur_n[k] = ftw_sh[k];
        if (sync_sh) acc_n[k] = '0;
      end
      // sample uses the post-commit offset and mode of this tick
      phase[k] = acc_n[k] + (apply ? off_sh[k] : off_a[k]);
      raw_n[k] = shape(phase[k], apply ? mode_sh[k] : mode_a[k]);
      prod[k]  = (2*DATA_W)'(raw_q[k]) * (2*DATA_W)'(amp_a[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        acc[k]     <= '0;
        ftw_cur[k] <= '0;
        ftw_st[k]  <= '0;
        off_a[k]   <= '0;
        step_a[k]  <= '0;
        lim_a[k]   <= '0;
        amp_a[k]   <= '1;
        mode_a[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        acc[k]     <= acc_n[k];
        ftw_cur[k] <= cur_n[k];
        if (apply) begin
          ftw_st[k] <= ftw_sh[k];
          off_a[k]  <= off_sh[k];
          step_a[k] <= step_sh[k];
          lim_a[k]  <= lim_sh[k];
          amp_a[k]  <= amp_sh[k];
          mode_a[k] <= mode_sh[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_v      <= 1'b0;
      wave_valid <= 1'b0;
      wave_out   <= '0;
      for (int k = 0; k < N_CH; k++) raw_q[k] <= '0;
    end else begin
      raw_v      <= tick;
      wave_valid <= raw_v;
      if (tick) begin
        for (int k = 0; k < N_CH; k++) raw_q[k] <= raw_n[k];
      end
      if (raw_v) begin
        for (int k = 0; k < N_CH; k++)
          wave_out[k*DATA_W +: DATA_W] <= prod[k][2*DATA_W-1 -: DATA_W];
      end
    end
  end

endmodule
